// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port sample RAM between rx (write), proc (read/write) and tx (read).
// Define ARB_PHASE_GATE_EN to gate request eligibility on the controller phase (status_i).
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [1:0]        status_i,

    input  logic              rx_req_i,
    input  logic [ADDR_W-1:0] rx_addr_i,
    input  logic [DATA_W-1:0] rx_wdata_i,
    output logic              rx_gnt_o,

    input  logic              proc_req_i,
    input  logic              proc_we_i,
    input  logic [ADDR_W-1:0] proc_addr_i,
    input  logic [DATA_W-1:0] proc_wdata_i,
    output logic              proc_gnt_o,
    output logic              proc_rvalid_o,

    input  logic              tx_req_i,
    input  logic [ADDR_W-1:0] tx_addr_i,
    output logic              tx_gnt_o,
    output logic              tx_rvalid_o,

    output logic [DATA_W-1:0] rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        RQ_RX   = 2'd0,
        RQ_PROC = 2'd1,
        RQ_TX   = 2'd2
    } rq_e;

    function automatic rq_e rq_next(input rq_e r);
        case (r)
            RQ_RX:   return RQ_PROC;
            RQ_PROC: return RQ_TX;
            default: return RQ_RX;
        endcase
    endfunction

    rq_e               ptr_q, ptr_d;
    logic [2:0]        gnt_q, gnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              proc_rvalid_q, proc_rvalid_d;
    logic              tx_rvalid_q, tx_rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              block_q, block_d;

    logic [2:0] phase_ok;
    logic [2:0] req_v;
    logic [2:0] elig;
    logic       win_vld;
    rq_e        win_sel;
    rq_e        p0, p1, p2;
    logic       rd_ret;

`ifdef ARB_PHASE_GATE_EN
    always_comb begin
        phase_ok = 3'b000;
        case (status_i)
            2'b00:   phase_ok = 3'b001;
            2'b01:   phase_ok = 3'b011;
            2'b10:   phase_ok = 3'b100;
            default: phase_ok = 3'b000;
        endcase
    end
`else
    logic unused_status;
    assign unused_status = ^status_i;
    assign phase_ok      = 3'b111;
`endif

    // A requester whose grant is showing this cycle is still holding the old request.
    assign req_v = {tx_req_i, proc_req_i, rx_req_i};
    assign elig  = req_v & ~gnt_q & phase_ok & {3{~block_q}};

    always_comb begin
        p0      = ptr_q;
        p1      = rq_next(p0);
        p2      = rq_next(p1);
        win_vld = |elig;
        win_sel = p2;
        if (elig[p0]) begin
            win_sel = p0;
        end else if (elig[p1]) begin
            win_sel = p1;
        end
    end

    always_comb begin
        ptr_d         = ptr_q;
        gnt_d         = 3'b000;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        block_d       = 1'b0;
        proc_rvalid_d = gnt_q[RQ_PROC] & ~mem_we_q;
        tx_rvalid_d   = gnt_q[RQ_TX];
        rdata_d       = rd_ret ? mem_rdata_i : rdata_q;
        if (win_vld) begin
            ptr_d    = rq_next(win_sel);
            gnt_d    = 3'b001 << win_sel;
            mem_en_d = 1'b1;
            case (win_sel)
                RQ_RX: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = rx_addr_i;
                    mem_wdata_d = rx_wdata_i;
                end
                RQ_PROC: begin
                    mem_we_d   = proc_we_i;
                    mem_addr_d = proc_addr_i;
                    if (proc_we_i) begin
                        mem_wdata_d = proc_wdata_i;
                    end
                end
                default: begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = tx_addr_i;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ptr_q         <= RQ_RX;
            gnt_q         <= 3'b000;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            proc_rvalid_q <= 1'b0;
            tx_rvalid_q   <= 1'b0;
            rdata_q       <= '0;
            block_q       <= 1'b1;
        end else begin
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            proc_rvalid_q <= proc_rvalid_d;
            tx_rvalid_q   <= tx_rvalid_d;
            rdata_q       <= rdata_d;
            block_q       <= block_d;
        end
    end

    // The RAM presents read data in the return cycle; it is passed through then and held afterwards.
    assign rd_ret        = proc_rvalid_q | tx_rvalid_q;
    assign rdata_o       = rd_ret ? mem_rdata_i : rdata_q;

    assign rx_gnt_o      = gnt_q[RQ_RX];
    assign proc_gnt_o    = gnt_q[RQ_PROC];
    assign tx_gnt_o      = gnt_q[RQ_TX];
    assign proc_rvalid_o = proc_rvalid_q;
    assign tx_rvalid_o   = tx_rvalid_q;
    assign mem_en_o      = mem_en_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous RAM model on the memory side.
// Phase-gating checks run only when ARB_PHASE_GATE_EN is defined; otherwise status is shown to be ignored.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  status;
    logic        rx_req;
    logic [15:0] rx_addr;
    logic [7:0]  rx_wdata;
    logic        rx_gnt;
    logic        proc_req;
    logic        proc_we;
    logic [15:0] proc_addr;
    logic [7:0]  proc_wdata;
    logic        proc_gnt;
    logic        proc_rvalid;
    logic        tx_req;
    logic [15:0] tx_addr;
    logic        tx_gnt;
    logic        tx_rvalid;
    logic [7:0]  rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  ram [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .clock_i       (clk),
        .reset_i       (reset),
        .status_i      (status),
        .rx_req_i      (rx_req),
        .rx_addr_i     (rx_addr),
        .rx_wdata_i    (rx_wdata),
        .rx_gnt_o      (rx_gnt),
        .proc_req_i    (proc_req),
        .proc_we_i     (proc_we),
        .proc_addr_i   (proc_addr),
        .proc_wdata_i  (proc_wdata),
        .proc_gnt_o    (proc_gnt),
        .proc_rvalid_o (proc_rvalid),
        .tx_req_i      (tx_req),
        .tx_addr_i     (tx_addr),
        .tx_gnt_o      (tx_gnt),
        .tx_rvalid_o   (tx_rvalid),
        .rdata_o       (rdata),
        .mem_en_o      (mem_en),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] gnts();
        return {tx_gnt, proc_gnt, rx_gnt};
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"},    {29'd0, gnts()}, 32'd0);
        chk({tag, "_en"},     {31'd0, mem_en}, 32'd0);
        chk({tag, "_we"},     {31'd0, mem_we}, 32'd0);
        chk({tag, "_addr"},   {16'd0, mem_addr}, 32'd0);
        chk({tag, "_wdata"},  {24'd0, mem_wdata}, 32'd0);
        chk({tag, "_rdata"},  {24'd0, rdata}, 32'd0);
        chk({tag, "_prv"},    {31'd0, proc_rvalid}, 32'd0);
        chk({tag, "_trv"},    {31'd0, tx_rvalid}, 32'd0);
    endtask

    logic [15:0] exp_addr [0:2];
    logic [7:0]  exp_rd   [0:2];

    initial begin
        reset = 1'b1; status = 2'b00;
        rx_req = 1'b0; rx_addr = '0; rx_wdata = '0;
        proc_req = 1'b0; proc_we = 1'b0; proc_addr = '0; proc_wdata = '0;
        tx_req = 1'b0; tx_addr = '0;

        // reset state
        tick(); tick(); tick();
        chk_idle_outputs("rst");

        reset = 1'b0;
        tick();
        chk("post_rst_dead_en", {31'd0, mem_en}, 32'd0);

        // rx write, one-cycle latency, no repeat while held
        rx_req = 1'b1; rx_addr = 16'h0010; rx_wdata = 8'hA5; status = 2'b00;
        tick();
        chk("rx_gnt",       {29'd0, gnts()}, 32'b001);
        chk("rx_en",        {31'd0, mem_en}, 32'd1);
        chk("rx_we",        {31'd0, mem_we}, 32'd1);
        chk("rx_addr",      {16'd0, mem_addr}, 32'h0010);
        chk("rx_wdata",     {24'd0, mem_wdata}, 32'hA5);
        tick();
        chk("rx_no_regnt",  {29'd0, gnts()}, 32'd0);
        chk("rx_idle_en",   {31'd0, mem_en}, 32'd0);
        chk("rx_idle_we",   {31'd0, mem_we}, 32'd0);
        chk("rx_hold_addr", {16'd0, mem_addr}, 32'h0010);
        rx_req = 1'b0;

        // proc read of what rx wrote
        status = 2'b01;
        proc_req = 1'b1; proc_we = 1'b0; proc_addr = 16'h0010; proc_wdata = 8'h00;
        tick();
        chk("prd_gnt",      {29'd0, gnts()}, 32'b010);
        chk("prd_en",       {31'd0, mem_en}, 32'd1);
        chk("prd_we",       {31'd0, mem_we}, 32'd0);
        chk("prd_addr",     {16'd0, mem_addr}, 32'h0010);
        chk("prd_rv_early", {31'd0, proc_rvalid}, 32'd0);
        proc_req = 1'b0;
        tick();
        chk("prd_rvalid",   {31'd0, proc_rvalid}, 32'd1);
        chk("prd_rdata",    {24'd0, rdata}, 32'hA5);
        chk("prd_tx_rv",    {31'd0, tx_rvalid}, 32'd0);
        tick();
        chk("prd_rv_end",   {31'd0, proc_rvalid}, 32'd0);
        chk("prd_rd_hold",  {24'd0, rdata}, 32'hA5);

        // proc write, then tx read of it
        proc_req = 1'b1; proc_we = 1'b1; proc_addr = 16'h0020; proc_wdata = 8'h3C;
        tick();
        chk("pwr_gnt",      {29'd0, gnts()}, 32'b010);
        chk("pwr_we",       {31'd0, mem_we}, 32'd1);
        chk("pwr_addr",     {16'd0, mem_addr}, 32'h0020);
        chk("pwr_wdata",    {24'd0, mem_wdata}, 32'h3C);
        proc_req = 1'b0;
        tick();
        chk("pwr_no_rv",    {31'd0, proc_rvalid}, 32'd0);

        status = 2'b10;
        tx_req = 1'b1; tx_addr = 16'h0020;
        tick();
        chk("trd_gnt",      {29'd0, gnts()}, 32'b100);
        chk("trd_en",       {31'd0, mem_en}, 32'd1);
        chk("trd_we",       {31'd0, mem_we}, 32'd0);
        chk("trd_addr",     {16'd0, mem_addr}, 32'h0020);
        tx_req = 1'b0;
        tick();
        chk("trd_rvalid",   {31'd0, tx_rvalid}, 32'd1);
        chk("trd_rdata",    {24'd0, rdata}, 32'h3C);
        chk("trd_prv",      {31'd0, proc_rvalid}, 32'd0);
        tick();

`ifdef ARB_PHASE_GATE_EN
        // tx held off in receive phase, granted once phase is transmit
        status = 2'b00; tx_req = 1'b1; tx_addr = 16'h0020;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("gate_rx_txgnt", {31'd0, tx_gnt}, 32'd0);
            chk("gate_rx_en",    {31'd0, mem_en}, 32'd0);
        end
        status = 2'b10;
        tick();
        chk("gate_tx_gnt", {29'd0, gnts()}, 32'b100);
        tx_req = 1'b0;
        tick();

        // finish phase: nothing granted
        status = 2'b11;
        rx_req = 1'b1; proc_req = 1'b1; tx_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("gate_fin_gnt", {29'd0, gnts()}, 32'd0);
            chk("gate_fin_en",  {31'd0, mem_en}, 32'd0);
        end
        rx_req = 1'b0; proc_req = 1'b0; tx_req = 1'b0;
        tick();

        // process phase: rx and proc alternate, tx still held off
        reset = 1'b1; tick(); reset = 1'b0; tick();
        status = 2'b01;
        rx_req = 1'b1; rx_addr = 16'h0030; rx_wdata = 8'h77;
        proc_req = 1'b1; proc_we = 1'b0; proc_addr = 16'h0010;
        tx_req = 1'b1; tx_addr = 16'h0020;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("gate_proc_gnt", {29'd0, gnts()}, (k % 2 == 0) ? 32'b001 : 32'b010);
        end
        rx_req = 1'b0; proc_req = 1'b0; tx_req = 1'b0;
        tick(); tick();
`else
        // status ignored: all three held in finish phase rotate rx, proc, tx
        reset = 1'b1; tick(); reset = 1'b0; tick();
        status = 2'b11;
        rx_req = 1'b1; rx_addr = 16'h0030; rx_wdata = 8'h77;
        proc_req = 1'b1; proc_we = 1'b0; proc_addr = 16'h0010;
        tx_req = 1'b1; tx_addr = 16'h0020;
        exp_addr[0] = 16'h0030; exp_addr[1] = 16'h0010; exp_addr[2] = 16'h0020;
        exp_rd[0]   = 8'h3C;    exp_rd[1]   = 8'h00;    exp_rd[2]   = 8'hA5;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_gnt",  {29'd0, gnts()}, 32'b001 << (k % 3));
            chk("rr_en",   {31'd0, mem_en}, 32'd1);
            chk("rr_addr", {16'd0, mem_addr}, {16'd0, exp_addr[k % 3]});
            chk("rr_prv",  {31'd0, proc_rvalid}, {31'd0, (k % 3 == 2)});
            chk("rr_trv",  {31'd0, tx_rvalid}, {31'd0, (k % 3 == 0) && (k > 0)});
            if ((k % 3 == 2) || ((k % 3 == 0) && (k > 0)))
                chk("rr_rdata", {24'd0, rdata}, {24'd0, exp_rd[k % 3]});
        end
        rx_req = 1'b0; proc_req = 1'b0; tx_req = 1'b0;
        tick(); tick();
`endif

        // reset during a granted proc read drops its rvalid
        status = 2'b01;
        proc_req = 1'b1; proc_we = 1'b0; proc_addr = 16'h0010;
        tick();
        chk("rma_gnt", {29'd0, gnts()}, 32'b010);
        reset = 1'b1; proc_req = 1'b0;
        tick();
        chk_idle_outputs("rma");
        reset = 1'b0;
        rx_req = 1'b1; rx_addr = 16'h0040; rx_wdata = 8'h11;
        proc_req = 1'b1; proc_we = 1'b1; proc_addr = 16'h0041; proc_wdata = 8'h22;
        tick();
        chk("rma_dead_en",  {31'd0, mem_en}, 32'd0);
        chk("rma_dead_gnt", {29'd0, gnts()}, 32'd0);
        tick();
        chk("rma_ptr_rx",   {29'd0, gnts()}, 32'b001);
        chk("rma_rx_addr",  {16'd0, mem_addr}, 32'h0040);
        rx_req = 1'b0; proc_req = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
